// File: rtl/ble_frame_rx.sv
// ble_frame_rx
//   UART deserialiser and framed command parser for the BLE link.
//   A frame is: SOF, LEN (must equal NUM_FIELDS), NUM_FIELDS payload bytes,
//   then CHK, where CHK = XOR of LEN and all payload bytes. A frame that
//   passes every check is copied into 'fields' in one cycle. A frame that
//   fails any check is dropped and reported on frame_err/err_code.
//
// Ports
//   clk, rst_n   system clock, async active-low reset
//   rxd          raw UART line (idle high, asynchronous to clk)
//   fields       last validated payload, fields[0] = first payload byte
//   frame_valid  1-cycle pulse when fields updates
//   frame_err    1-cycle pulse on any rejected byte or frame
//   err_code     cause of last error: 0 framing, 1 length, 2 checksum, 3 timeout
//   good_count   accepted frames, saturating
//   bad_count    frame_err pulses, saturating
module ble_frame_rx #(
  parameter int          CLK_FREQ       = 100_000_000,
  parameter int          BAUD           = 115200,
  parameter int          NUM_FIELDS     = 10,
  parameter logic [7:0]  SOF            = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 100_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rxd,
  output logic [NUM_FIELDS-1:0][7:0] fields,
  output logic                       frame_valid,
  output logic                       frame_err,
  output logic [1:0]                 err_code,
  output logic [15:0]                good_count,
  output logic [15:0]                bad_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

  localparam logic [1:0] U_IDLE  = 2'd0;
  localparam logic [1:0] U_START = 2'd1;
  localparam logic [1:0] U_DATA  = 2'd2;
  localparam logic [1:0] U_STOP  = 2'd3;

  localparam logic [1:0] F_SOF = 2'd0;
  localparam logic [1:0] F_LEN = 2'd1;
  localparam logic [1:0] F_PAY = 2'd2;
  localparam logic [1:0] F_CHK = 2'd3;

  localparam logic [1:0] E_FRAMING  = 2'd0;
  localparam logic [1:0] E_LENGTH   = 2'd1;
  localparam logic [1:0] E_CHECKSUM = 2'd2;
  localparam logic [1:0] E_TIMEOUT  = 2'd3;

  // ---------------------------------------------------------------------
  // Synchroniser. rxd_q is one more delay used only for edge detection.
  // ---------------------------------------------------------------------
  logic rxd_m, rxd_s, rxd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_q <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_q <= rxd_s;
    end
  end

  // ---------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------
  logic [1:0]    ustate;
  logic [CW-1:0] ucnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          byte_valid;
  logic          ferr;
  logic [7:0]    rx_byte;

  // shreg is not touched in STOP, so it still holds the byte during the
  // byte_valid pulse that follows the stop sample.
  assign rx_byte = shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ustate     <= U_IDLE;
      ucnt       <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      ferr       <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      ferr       <= 1'b0;
      case (ustate)
        U_IDLE: begin
          // A true 1->0 edge is required, so a line left low after a bad
          // stop bit does not immediately start a phantom byte.
          if (rxd_q && !rxd_s) begin
            ustate <= U_START;
            ucnt   <= CW'(CLKS_PER_BIT / 2);
          end
        end
        U_START: begin
          if (ucnt == '0) begin
            if (rxd_s) begin
              ustate <= U_IDLE;          // glitch, not a start bit
            end else begin
              ustate  <= U_DATA;
              ucnt    <= CW'(CLKS_PER_BIT - 1);
              bit_idx <= '0;
            end
          end else begin
            ucnt <= ucnt - 1'b1;
          end
        end
        U_DATA: begin
          if (ucnt == '0) begin
            shreg   <= {rxd_s, shreg[7:1]};   // LSB first
            ucnt    <= CW'(CLKS_PER_BIT - 1);
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) ustate <= U_STOP;
          end else begin
            ucnt <= ucnt - 1'b1;
          end
        end
        default: begin // U_STOP
          if (ucnt == '0) begin
            if (rxd_s) byte_valid <= 1'b1;
            else       ferr       <= 1'b1;
            ustate <= U_IDLE;
          end else begin
            ucnt <= ucnt - 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Frame parser
  // ---------------------------------------------------------------------
  logic [1:0]                 fstate;
  logic [IW-1:0]              idx;
  logic [7:0]                 chk;
  logic [TW-1:0]              tcnt;
  logic [NUM_FIELDS-1:0][7:0] shadow;
  logic                       tmo;
  logic                       err_hit;
  logic [1:0]                 err_nxt;
  logic                       pay_wr;

  // A byte arriving in the expiry cycle keeps the frame alive.
  assign tmo    = (fstate != F_SOF) && (tcnt == TW'(TIMEOUT_CYCLES - 1)) && !byte_valid;
  assign pay_wr = byte_valid && (fstate == F_PAY);

  always_comb begin
    err_hit = 1'b0;
    err_nxt = err_code;
    if (ferr) begin
      err_hit = 1'b1;
      err_nxt = E_FRAMING;
    end else if (tmo) begin
      err_hit = 1'b1;
      err_nxt = E_TIMEOUT;
    end else if (byte_valid && fstate == F_LEN && rx_byte != 8'(NUM_FIELDS)) begin
      err_hit = 1'b1;
      err_nxt = E_LENGTH;
    end else if (byte_valid && fstate == F_CHK && rx_byte != chk) begin
      err_hit = 1'b1;
      err_nxt = E_CHECKSUM;
    end
  end

  // Shadow payload, one byte lane per field. Contents only matter once a
  // whole frame has been collected, so these flops carry no reset.
  genvar g;
  generate
    for (g = 0; g < NUM_FIELDS; g++) begin : g_shadow
      always_ff @(posedge clk) begin
        if (pay_wr && idx == IW'(g)) shadow[g] <= rx_byte;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fstate      <= F_SOF;
      idx         <= '0;
      chk         <= '0;
      tcnt        <= '0;
      fields      <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= '0;
      good_count  <= '0;
      bad_count   <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= err_hit;

      if (err_hit) begin
        err_code <= err_nxt;
        if (bad_count != 16'hFFFF) bad_count <= bad_count + 1'b1;
      end

      if (byte_valid || fstate == F_SOF) tcnt <= '0;
      else                               tcnt <= tcnt + 1'b1;

      if (ferr || tmo) begin
        fstate <= F_SOF;
      end else if (byte_valid) begin
        case (fstate)
          F_SOF: if (rx_byte == SOF) fstate <= F_LEN;
          F_LEN: begin
            if (rx_byte == 8'(NUM_FIELDS)) begin
              fstate <= F_PAY;
              idx    <= '0;
              chk    <= rx_byte;
            end else begin
              fstate <= F_SOF;
            end
          end
          F_PAY: begin
            chk <= chk ^ rx_byte;
            idx <= idx + 1'b1;
            if (idx == IW'(NUM_FIELDS - 1)) fstate <= F_CHK;
          end
          default: begin // F_CHK
            if (rx_byte == chk) begin
              fields      <= shadow;
              frame_valid <= 1'b1;
              if (good_count != 16'hFFFF) good_count <= good_count + 1'b1;
            end
            fstate <= F_SOF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ble_frame_rx.sv
// Randomised frame-level bench for ble_frame_rx. Each transaction is a
// whole frame chosen from a small set of kinds (good, bad checksum, bad
// length, timeout, bad stop bit mid-frame, bad stop bit while idle); the
// expected outcome follows directly from the kind.
module tb_ble_frame_rx;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int NF       = 10;
  localparam int TMO      = 1000;
  localparam logic [7:0] SOFB = 8'hA5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                rxd = 1'b1;
  logic [NF-1:0][7:0]  fields;
  logic                frame_valid, frame_err;
  logic [1:0]          err_code;
  logic [15:0]         good_count, bad_count;

  ble_frame_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .NUM_FIELDS(NF),
                 .SOF(SOFB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .fields(fields),
    .frame_valid(frame_valid), .frame_err(frame_err), .err_code(err_code),
    .good_count(good_count), .bad_count(bad_count));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int nv = 0;   // frame_valid pulses seen
  int ne = 0;   // frame_err pulses seen

  always @(negedge clk) if (rst_n) begin
    if (frame_valid) nv++;
    if (frame_err)   ne++;
  end

  // Reference state
  logic [NF-1:0][7:0] m_fields = '0;
  int                 m_good = 0;
  int                 m_bad  = 0;
  logic [1:0]         m_code = 2'd0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk) rxd = v;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok);
    @(negedge clk) rxd = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_fields"}, 128'(fields), 128'(m_fields));
    check({tag, "_good"}, 128'(good_count), 128'(m_good));
    check({tag, "_bad"}, 128'(bad_count), 128'(m_bad));
    check({tag, "_code"}, 128'(err_code), 128'(m_code));
  endtask

  // kind: 0 good, 1 bad checksum (xo != 0 flips it), 2 bad length,
  //       3 timeout after k payload bytes, 4 bad stop bit at payload slot k
  //       (k == NF means the checksum slot), 5 bad stop bit while idle
  task automatic run_frame(input string tag, input int kind,
                           input logic [NF-1:0][7:0] pl, input int k,
                           input logic [7:0] xo);
    int v0, e0, exp_v, exp_e;
    logic [7:0] cs, len;
    v0 = nv; e0 = ne;
    cs = 8'(NF);
    for (int i = 0; i < NF; i++) cs ^= pl[i];
    exp_v = 0; exp_e = 1;
    case (kind)
      0: begin
        send_byte(SOFB, 1'b1); send_byte(8'(NF), 1'b1);
        for (int i = 0; i < NF; i++) send_byte(pl[i], 1'b1);
        send_byte(cs, 1'b1);
        exp_v = 1; exp_e = 0;
        m_fields = pl;
        m_good++;
      end
      1: begin
        send_byte(SOFB, 1'b1); send_byte(8'(NF), 1'b1);
        for (int i = 0; i < NF; i++) send_byte(pl[i], 1'b1);
        send_byte(cs ^ xo, 1'b1);
        m_code = 2'd2;
      end
      2: begin
        len = 8'($urandom_range(0, 255));
        if (len == 8'(NF)) len = len + 8'd1;
        send_byte(SOFB, 1'b1); send_byte(len, 1'b1);
        m_code = 2'd1;
      end
      3: begin
        send_byte(SOFB, 1'b1); send_byte(8'(NF), 1'b1);
        for (int i = 0; i < k; i++) send_byte(pl[i], 1'b1);
        repeat (TMO + 10) @(negedge clk);
        m_code = 2'd3;
      end
      4: begin
        send_byte(SOFB, 1'b1); send_byte(8'(NF), 1'b1);
        for (int i = 0; i < k; i++) send_byte(pl[i], 1'b1);
        send_byte(8'($urandom_range(0, 255)), 1'b0);
        m_code = 2'd0;
      end
      default: begin
        send_byte(8'($urandom_range(0, 255)), 1'b0);
        m_code = 2'd0;
      end
    endcase
    if (exp_e != 0) m_bad++;
    repeat (3 * CPB) @(negedge clk);
    check({tag, "_nvalid"}, 128'(nv - v0), 128'(exp_v));
    check({tag, "_nerr"}, 128'(ne - e0), 128'(exp_e));
    check_state(tag);
  endtask

  logic [NF-1:0][7:0] pl;
  int v0, e0;

  initial begin
    repeat (5) @(negedge clk);
    check("rst_fields", 128'(fields), 128'(0));
    check("rst_fv", 128'(frame_valid), 128'(0));
    check("rst_fe", 128'(frame_err), 128'(0));
    check("rst_code", 128'(err_code), 128'(0));
    check("rst_good", 128'(good_count), 128'(0));
    check("rst_bad", 128'(bad_count), 128'(0));
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    for (int i = 0; i < NF; i++) pl[i] = 8'(i + 1);
    run_frame("good_a", 0, pl, 0, 8'h00);
    run_frame("bad_chk", 1, pl, 0, 8'h03);      // checksum byte 02
    run_frame("bad_len", 2, pl, 0, 8'h00);
    for (int i = 0; i < NF; i++) pl[i] = (i % 3 == 0) ? SOFB : 8'($urandom_range(0, 255));
    run_frame("good_sofdata", 0, pl, 0, 8'h00);
    run_frame("timeout", 3, pl, 2, 8'h00);
    run_frame("good_after_tmo", 0, pl, 0, 8'h00);

    // Quarter-bit low glitch: no byte, no error.
    v0 = nv; e0 = ne;
    @(negedge clk) rxd = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_nvalid", 128'(nv - v0), 128'(0));
    check("glitch_nerr", 128'(ne - e0), 128'(0));
    check_state("glitch");

    run_frame("stop0_mid", 4, pl, 5, 8'h00);
    run_frame("stop0_idle", 5, pl, 0, 8'h00);

    // Randomised mix
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < NF; i++) pl[i] = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 5))
        0, 1: run_frame($sformatf("r%0d_good", t), 0, pl, 0, 8'h00);
        2:    run_frame($sformatf("r%0d_chk", t), 1, pl, 0, 8'($urandom_range(1, 255)));
        3:    run_frame($sformatf("r%0d_len", t), 2, pl, 0, 8'h00);
        4:    run_frame($sformatf("r%0d_tmo", t), 3, pl, $urandom_range(0, NF), 8'h00);
        default: run_frame($sformatf("r%0d_stop", t), 4, pl, $urandom_range(0, NF), 8'h00);
      endcase
    end

    // Reset in the middle of a payload
    send_byte(SOFB, 1'b1); send_byte(8'(NF), 1'b1);
    for (int i = 0; i < 3; i++) send_byte(pl[i], 1'b1);
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(negedge clk);
    m_fields = '0; m_good = 0; m_bad = 0; m_code = 2'd0;
    check("midrst_fv", 128'(frame_valid), 128'(0));
    check("midrst_fe", 128'(frame_err), 128'(0));
    check_state("midrst");
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    for (int i = 0; i < NF; i++) pl[i] = 8'($urandom_range(0, 255));
    run_frame("post_rst", 0, pl, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ble_frame_rx.md
Name: ble_frame_rx

Overview:
- Next-generation BLE command receiver: UART deserialiser plus framed-packet parser in one block.
- Replaces newline-delimited packets with SOF/length/payload/checksum frames.
- Adds stop-bit checking, a start-bit glitch filter, an inter-byte timeout and error counters.
- Drives a parametrised bank of byte-wide command fields (PID gains, setpoints, init flags) to the flight-control logic; fields update atomically only on a fully validated frame.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD
- NUM_FIELDS, 10, payload bytes per frame (1..255)
- SOF, 8'hA5, start-of-frame byte value
- TIMEOUT_CYCLES, 100_000, maximum idle clocks between bytes inside a frame

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- rxd  in  1  UART line from the BLE module (idle high, asynchronous to clk)
- fields  out  [NUM_FIELDS-1:0][7:0]  last validated payload; fields[0] = first payload byte
- frame_valid  out  1  1-cycle pulse when fields updates
- frame_err  out  1  1-cycle pulse on any rejected byte or frame
- err_code  out  2  cause of the last frame_err: 0 framing, 1 length, 2 checksum, 3 timeout; holds until the next error
- good_count  out  16  number of accepted frames, saturates at 16'hFFFF
- bad_count  out  16  number of frame_err pulses, saturates at 16'hFFFF

Behaviour:
- Reset (rst_n low, any time, including mid-frame): fields, frame_valid, frame_err, err_code, good_count and bad_count go to 0. Both FSMs go to idle. The rxd synchroniser goes to 1. Shadow buffer contents are don't-care.
- rxd passes through a 2-flop synchroniser; all logic uses the synchronised value.
- UART FSM, states IDLE, START, DATA, STOP:
  - IDLE: falling edge (0) -> START with the counter at CLKS_PER_BIT/2.
  - START: at count 0, re-sample; if 1 it was a glitch -> IDLE with no byte and no error; else -> DATA.
  - DATA: sample 8 bits LSB-first, one every CLKS_PER_BIT.
  - STOP: sample the stop bit; 1 -> internal byte_valid pulse with the byte; 0 -> framing error, byte discarded.
  - Every STOP sample returns to IDLE.
- Frame FSM, states F_SOF, F_LEN, F_PAY, F_CHK; advances only on byte_valid:
  - F_SOF: byte==SOF -> F_LEN; any other byte is silently ignored (no error).
  - F_LEN: byte==NUM_FIELDS -> F_PAY, idx=0, chk=byte; else length error -> F_SOF.
  - F_PAY: shadow[idx]=byte, chk^=byte, idx++; after idx==NUM_FIELDS-1 -> F_CHK.
  - F_CHK: byte==chk -> copy shadow to fields, frame_valid=1, good_count++; else checksum error. Both outcomes -> F_SOF.
- Checksum = XOR of the LEN byte and all payload bytes. SOF is excluded.
- Timeout: an idle counter clears on every byte_valid and runs only while not in F_SOF. Reaching TIMEOUT_CYCLES -> timeout error -> F_SOF. If byte_valid and expiry fall in the same cycle, the byte wins (no error).
- A UART framing error in any frame state -> framing error, frame FSM -> F_SOF. A framing error in F_SOF also flags, but the FSM stays in F_SOF.
- Every error: frame_err=1 for 1 cycle, err_code updated, bad_count++. Counters saturate, no wrap.
- Latency: frame_valid and the new fields appear in the cycle after the byte_valid of the checksum byte. fields are never partially updated and hold between good frames.
- A SOF value occurring inside the payload is data, not a resync.

Test Plan:
- Frame A5 0A 01 02 03 04 05 06 07 08 09 0A 01 -> one frame_valid; fields[0..9]=01..0A; good_count=1; bad_count=0.
- Same frame with last byte 02 -> frame_err, err_code=2; fields unchanged from the previous frame; bad_count=1.
- A5 05 ... -> frame_err, err_code=1 right after the LEN byte. Then a valid frame sent immediately -> accepted.
- A5 0A 01 02, then idle TIMEOUT_CYCLES+10 clocks -> frame_err, err_code=3. A following valid frame is accepted.
- 1/4-bit low glitch on rxd -> no byte, no error. Byte with stop bit 0 mid-payload -> err_code=0, frame aborted.
- rst_n pulsed low mid-payload -> all outputs 0. The next complete valid frame -> frame_valid, good_count=1.
